cnt_select_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH-bit display/output channel between two counter sources (requester 1, requester 2).
- Grants one source at a time for at most HOLD cycles, then hands over if the other source is waiting.
- Drives the select line and a registered copy of the granted value.
- Sits between the counter blocks and the display/ALU stage that consumes a single count.

---
 rtl/cnt_select_arbiter_if.sv | 24 ++
 rtl/cnt_select_arbiter.sv | 97 +++++++++
 tb/tb_cnt_select_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cnt_select_arbiter_if.sv
// rtl/cnt_select_arbiter_if.sv - request/grant/count bundle between two counters and the arbiter
interface cnt_select_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             REQ1;
  logic             REQ2;
  logic [WIDTH-1:0] CNT1;
  logic [WIDTH-1:0] CNT2;
  logic             GNT1;
  logic             GNT2;
  logic             SW;
  logic [WIDTH-1:0] CNT;
  logic             VALID;

  modport master (
    output REQ1, REQ2, CNT1, CNT2,
    input  GNT1, GNT2, SW, CNT, VALID
  );

  modport slave (
    input  REQ1, REQ2, CNT1, CNT2,
    output GNT1, GNT2, SW, CNT, VALID
  );
endinterface

// File: rtl/cnt_select_arbiter.sv
// rtl/cnt_select_arbiter.sv - round-robin share of one count channel between two counter sources
module cnt_select_arbiter #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 8
) (
  input logic                 CLK,
  input logic                 RST,
  cnt_select_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_t           state_q, state_d;
  logic             sw_q, sw_d;
  // last uses the select encoding (1 = source 2), so reset value 1 hands the first tie to source 1
  logic             last_q, last_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]       dwell_q, dwell_d;

  logic             pick;
  logic             req_s, req_o;
  logic [WIDTH-1:0] cnt_s, cnt_o;
  logic             rel;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sw_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      dwell_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;

    if (bus.REQ1 && !bus.REQ2)      pick = 1'b0;
    else if (bus.REQ2 && !bus.REQ1) pick = 1'b1;
    else                            pick = ~last_q;

    req_s = sw_q ? bus.REQ2 : bus.REQ1;
    req_o = sw_q ? bus.REQ1 : bus.REQ2;
    cnt_s = sw_q ? bus.CNT2 : bus.CNT1;
    cnt_o = sw_q ? bus.CNT1 : bus.CNT2;
    rel   = !req_s || (dwell_q == 8'd0);

    case (state_q)
      IDLE: begin
        if (bus.REQ1 || bus.REQ2) begin
          state_d = GRANT;
          sw_d    = pick;
          last_d  = pick;
          cnt_d   = pick ? bus.CNT2 : bus.CNT1;
          dwell_d = HOLD_M1;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_d   = cnt_s;
          dwell_d = dwell_q - 8'd1;
        end else if (req_o) begin
          // hand over in the same edge so the channel never goes idle
          sw_d    = ~sw_q;
          last_d  = ~sw_q;
          cnt_d   = cnt_o;
          dwell_d = HOLD_M1;
        end else if (req_s) begin
          cnt_d   = cnt_s;
          dwell_d = HOLD_M1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.VALID = (state_q == GRANT);
    bus.GNT1  = (state_q == GRANT) && !sw_q;
    bus.GNT2  = (state_q == GRANT) && sw_q;
    bus.SW    = sw_q;
    bus.CNT   = cnt_q;
  end
endmodule

// File: tb/tb_cnt_select_arbiter.sv
// tb/tb_cnt_select_arbiter.sv - directed checks of the two-source count arbiter at HOLD 8, 4 and 1
module tb_cnt_select_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  cnt_select_arbiter_if #(.WIDTH(4)) i8 ();
  cnt_select_arbiter_if #(.WIDTH(4)) i4 ();
  cnt_select_arbiter_if #(.WIDTH(4)) i1 ();

  cnt_select_arbiter #(.WIDTH(4), .HOLD(8)) u8 (.CLK(CLK), .RST(RST), .bus(i8));
  cnt_select_arbiter #(.WIDTH(4), .HOLD(4)) u4 (.CLK(CLK), .RST(RST), .bus(i4));
  cnt_select_arbiter #(.WIDTH(4), .HOLD(1)) u1 (.CLK(CLK), .RST(RST), .bus(i1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    i8.REQ1 = 0; i8.REQ2 = 0; i8.CNT1 = 0; i8.CNT2 = 0;
    i4.REQ1 = 0; i4.REQ2 = 0; i4.CNT1 = 0; i4.CNT2 = 0;
    i1.REQ1 = 0; i1.REQ2 = 0; i1.CNT1 = 0; i1.CNT2 = 0;
    tick();
    tick();
    RST = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d_gnt1", i), i8.GNT1, 0);
      check($sformatf("idle%0d_gnt2", i), i8.GNT2, 0);
      check($sformatf("idle%0d_valid", i), i8.VALID, 0);
      check($sformatf("idle%0d_sw", i), i8.SW, 0);
      check($sformatf("idle%0d_cnt", i), i8.CNT, 0);
    end

    // single requester, HOLD=8: continuous grant across dwell expiry
    i8.REQ1 = 1; i8.CNT1 = 4'h5;
    tick();
    check("single_gnt1", i8.GNT1, 1);
    check("single_sw", i8.SW, 0);
    check("single_valid", i8.VALID, 1);
    check("single_cnt", i8.CNT, 5);
    for (int i = 0; i < 20; i++) begin
      i8.CNT1 = 4'((i * 7 + 3) % 16);
      tick();
      check($sformatf("single%0d_gnt1", i), i8.GNT1, 1);
      check($sformatf("single%0d_gnt2", i), i8.GNT2, 0);
      check($sformatf("single%0d_cnt", i), i8.CNT, (i * 7 + 3) % 16);
    end
    i8.REQ1 = 0; i8.CNT1 = 4'hA;
    tick();
    check("single_drop_valid", i8.VALID, 0);
    check("single_drop_gnt1", i8.GNT1, 0);
    check("single_drop_cnt", i8.CNT, (19 * 7 + 3) % 16);

    // both request from reset, HOLD=4: 4 x src1, 4 x src2, 4 x src1
    i4.CNT1 = 4'd3; i4.CNT2 = 4'd9; i4.REQ1 = 1; i4.REQ2 = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("rr%0d_valid", i), i4.VALID, 1);
      check($sformatf("rr%0d_gnt1", i), i4.GNT1, ((i / 4) % 2) == 0);
      check($sformatf("rr%0d_gnt2", i), i4.GNT2, ((i / 4) % 2) == 1);
      check($sformatf("rr%0d_sw", i), i4.SW, ((i / 4) % 2) == 1);
      check($sformatf("rr%0d_cnt", i), i4.CNT, (((i / 4) % 2) == 0) ? 3 : 9);
    end

    // src1 leaves, src2 takes over, then src2 leaves -> idle with SW/CNT held
    i4.REQ1 = 0;
    tick();
    check("hand_gnt2", i4.GNT2, 1);
    check("hand_sw", i4.SW, 1);
    check("hand_cnt", i4.CNT, 9);
    i4.CNT2 = 4'd7;
    tick();
    check("track_cnt", i4.CNT, 7);
    i4.REQ2 = 0; i4.CNT2 = 4'd2;
    tick();
    check("drop2_valid", i4.VALID, 0);
    check("drop2_gnt2", i4.GNT2, 0);
    check("drop2_sw", i4.SW, 1);
    check("drop2_cnt", i4.CNT, 7);

    // reset mid-tenure; tie after reset goes to src1
    i4.REQ1 = 1; i4.CNT1 = 4'd6;
    tick();
    tick();
    check("pre_rst_gnt1", i4.GNT1, 1);
    RST = 1; i4.REQ2 = 1;
    tick();
    check("rst_gnt1", i4.GNT1, 0);
    check("rst_gnt2", i4.GNT2, 0);
    check("rst_valid", i4.VALID, 0);
    check("rst_sw", i4.SW, 0);
    check("rst_cnt", i4.CNT, 0);
    RST = 0;
    tick();
    check("post_rst_gnt1", i4.GNT1, 1);
    check("post_rst_cnt", i4.CNT, 6);
    i4.REQ1 = 0; i4.REQ2 = 0;

    // HOLD=1: alternate every cycle
    i1.CNT1 = 4'd1; i1.CNT2 = 4'd14; i1.REQ1 = 1; i1.REQ2 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("h1_%0d_sw", i), i1.SW, i % 2);
      check($sformatf("h1_%0d_gnt1", i), i1.GNT1, (i % 2) == 0);
      check($sformatf("h1_%0d_gnt2", i), i1.GNT2, (i % 2) == 1);
      check($sformatf("h1_%0d_cnt", i), i1.CNT, ((i % 2) == 0) ? 1 : 14);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
